// File: rtl/prv_trap_ctrl_if.sv
// -----------------------------------------------------------------------------
// prv_trap_ctrl_if
// Privilege/pipeline trap interface between the hazard unit, the trap
// controller and the machine-mode CSR file.
//
// Signals driven toward the trap controller (master -> slave):
//   exc_vec[11:0]    exception flags of the retiring instruction
//   mret, wfi        mret / wfi retiring
//   pipe_clear       pipeline drained
//   epc, badaddr     faulting pc and faulting address
//   curr_priv[1:0]   current privilege level (U=0, S=1, M=3)
//   timer_int, soft_int, ext_int   raw interrupt lines
//   mstatus_mie      global interrupt enable
//   mie_bits[2:0]    {MEIE, MTIE, MSIE}
//   mtvec            trap vector, [1:0] 0=direct 1=vectored
//   mepc_r           current mepc, the mret target
// Signals driven by the trap controller (slave -> master):
//   insert_pc, priv_pc        redirect strobe and target
//   intr                      trap in progress is an interrupt
//   trap_commit, mret_commit  one-cycle CSR file strobes
//   mepc_o, mcause_o, mtval_o trap CSR values
//   wfi_sleep                 core halted in WFI
//
// Handshake: there is no valid/ready pair. The hazard unit keeps exc_vec,
// mret, wfi, epc and badaddr stable while a trap is draining; insert_pc is a
// single-cycle strobe that the pipeline must act on in the cycle it is seen.
// -----------------------------------------------------------------------------
interface prv_trap_ctrl_if #(
   parameter int XLEN = 32
);
   logic [11:0]     exc_vec;
   logic            mret;
   logic            wfi;
   logic            pipe_clear;
   logic [XLEN-1:0] epc;
   logic [XLEN-1:0] badaddr;
   logic [1:0]      curr_priv;
   logic            timer_int;
   logic            soft_int;
   logic            ext_int;
   logic            mstatus_mie;
   logic [2:0]      mie_bits;
   logic [XLEN-1:0] mtvec;
   logic [XLEN-1:0] mepc_r;

   logic            insert_pc;
   logic [XLEN-1:0] priv_pc;
   logic            intr;
   logic            trap_commit;
   logic            mret_commit;
   logic [XLEN-1:0] mepc_o;
   logic [XLEN-1:0] mcause_o;
   logic [XLEN-1:0] mtval_o;
   logic            wfi_sleep;

   modport master (
      output exc_vec, mret, wfi, pipe_clear, epc, badaddr, curr_priv,
             timer_int, soft_int, ext_int, mstatus_mie, mie_bits, mtvec, mepc_r,
      input  insert_pc, priv_pc, intr, trap_commit, mret_commit,
             mepc_o, mcause_o, mtval_o, wfi_sleep
   );

   modport slave (
      input  exc_vec, mret, wfi, pipe_clear, epc, badaddr, curr_priv,
             timer_int, soft_int, ext_int, mstatus_mie, mie_bits, mtvec, mepc_r,
      output insert_pc, priv_pc, intr, trap_commit, mret_commit,
             mepc_o, mcause_o, mtval_o, wfi_sleep
   );
endinterface

// File: rtl/prv_trap_ctrl.sv
// -----------------------------------------------------------------------------
// prv_trap_ctrl
// Machine-mode trap controller. Prioritises exceptions, interrupts and mret,
// latches mcause/mtval/mepc, waits for the pipeline to drain and then
// redirects it through insert_pc/priv_pc, emitting one-cycle commit strobes
// to the CSR file. Also parks the core in WFI until an enabled interrupt
// line goes pending.
//
// Ports:
//   CLK          clock
//   RST          asynchronous active-high reset
//   trap_bus     prv_trap_ctrl_if.slave (see interface header)
//   dbg_state_o  current FSM state (0 IDLE, 1 DRAIN, 2 INSERT, 3 SLEEP)
// -----------------------------------------------------------------------------
module prv_trap_ctrl #(
   parameter int              XLEN      = 32,
   parameter logic [XLEN-1:0] RESET_VEC = 'h0000_0200
) (
   input  logic              CLK,
   input  logic              RST,
   prv_trap_ctrl_if.slave    trap_bus,
   output logic [1:0]        dbg_state_o
);

   typedef enum logic [1:0] {
      S_IDLE   = 2'd0,
      S_DRAIN  = 2'd1,
      S_INSERT = 2'd2,
      S_SLEEP  = 2'd3
   } state_t;

   state_t          state_q;
   logic [XLEN-1:0] cause_q, tval_q, mepc_q;
   logic [3:0]      int_code_q;
   logic            intr_q, is_mret_q;
   logic            insert_pc_q, trap_commit_q, mret_commit_q, wfi_sleep_q;

   logic [2:0]      pend;
   logic            take_int, exc_any;
   logic [3:0]      int_code_d;
   logic [XLEN-1:0] cause_d, tval_d, mepc_d;
   logic [XLEN-1:0] base;
   logic [XLEN-1:0] priv_pc_d;

   // mie_bits is {MEIE, MTIE, MSIE}; pend is ordered {ext, soft, timer}.
   assign pend     = {trap_bus.ext_int   & trap_bus.mie_bits[2],
                      trap_bus.soft_int  & trap_bus.mie_bits[0],
                      trap_bus.timer_int & trap_bus.mie_bits[1]};
   assign take_int = trap_bus.mstatus_mie & (|pend);
   assign exc_any  = |trap_bus.exc_vec;
   assign mepc_d   = {trap_bus.epc[XLEN-1:2], 2'b00};

   always_comb begin
      int_code_d = 4'd7;
      if (pend[2])      int_code_d = 4'd11;
      else if (pend[1]) int_code_d = 4'd3;
   end

   // Cause/tval selection; exceptions first in fixed priority, then interrupt.
   always_comb begin
      cause_d = '0;
      tval_d  = '0;
      if (trap_bus.exc_vec[3]) begin
         cause_d = XLEN'(3);
         tval_d  = trap_bus.epc;
      end else if (trap_bus.exc_vec[9]) begin
         cause_d = XLEN'(12);
         tval_d  = trap_bus.badaddr;
      end else if (trap_bus.exc_vec[0]) begin
         cause_d = XLEN'(1);
         tval_d  = trap_bus.badaddr;
      end else if (trap_bus.exc_vec[2]) begin
         cause_d = XLEN'(2);
      end else if (trap_bus.exc_vec[1]) begin
         cause_d = XLEN'(0);
         tval_d  = trap_bus.badaddr;
      end else if (trap_bus.exc_vec[4]) begin
         // 8 + curr_priv, curr_priv never exceeds 3
         cause_d = {{(XLEN-4){1'b0}}, 2'b10, trap_bus.curr_priv};
      end else if (trap_bus.exc_vec[8]) begin
         cause_d = XLEN'(6);
         tval_d  = trap_bus.badaddr;
      end else if (trap_bus.exc_vec[6]) begin
         cause_d = XLEN'(4);
         tval_d  = trap_bus.badaddr;
      end else if (trap_bus.exc_vec[11]) begin
         cause_d = XLEN'(15);
         tval_d  = trap_bus.badaddr;
      end else if (trap_bus.exc_vec[10]) begin
         cause_d = XLEN'(13);
         tval_d  = trap_bus.badaddr;
      end else if (trap_bus.exc_vec[7]) begin
         cause_d = XLEN'(7);
         tval_d  = trap_bus.badaddr;
      end else if (trap_bus.exc_vec[5]) begin
         cause_d = XLEN'(5);
         tval_d  = trap_bus.badaddr;
      end else begin
         cause_d = {1'b1, {(XLEN-5){1'b0}}, int_code_d};
      end
   end

   // Redirect target; only meaningful while INSERT, RESET_VEC otherwise.
   assign base = {trap_bus.mtvec[XLEN-1:2], 2'b00};

   always_comb begin
      priv_pc_d = RESET_VEC;
      if (state_q == S_INSERT) begin
         if (is_mret_q)
            priv_pc_d = trap_bus.mepc_r;
         else if (intr_q && (trap_bus.mtvec[1:0] == 2'b01))
            priv_pc_d = base + {{(XLEN-6){1'b0}}, int_code_q, 2'b00};
         else
            priv_pc_d = base;
      end
   end

   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         state_q       <= S_IDLE;
         cause_q       <= '0;
         tval_q        <= '0;
         mepc_q        <= '0;
         int_code_q    <= '0;
         intr_q        <= 1'b0;
         is_mret_q     <= 1'b0;
         insert_pc_q   <= 1'b0;
         trap_commit_q <= 1'b0;
         mret_commit_q <= 1'b0;
         wfi_sleep_q   <= 1'b0;
      end else begin
         insert_pc_q   <= 1'b0;
         trap_commit_q <= 1'b0;
         mret_commit_q <= 1'b0;
         case (state_q)
            S_IDLE: begin
               if (exc_any || take_int) begin
                  cause_q    <= cause_d;
                  tval_q     <= tval_d;
                  mepc_q     <= mepc_d;
                  int_code_q <= int_code_d;
                  intr_q     <= ~exc_any;
                  is_mret_q  <= 1'b0;
                  state_q    <= S_DRAIN;
               end else if (trap_bus.mret) begin
                  is_mret_q  <= 1'b1;
                  intr_q     <= 1'b0;
                  state_q    <= S_DRAIN;
               end else if (trap_bus.wfi && (pend == 3'b000)) begin
                  wfi_sleep_q <= 1'b1;
                  state_q     <= S_SLEEP;
               end
            end
            S_DRAIN: begin
               if (trap_bus.pipe_clear) begin
                  insert_pc_q   <= 1'b1;
                  trap_commit_q <= ~is_mret_q;
                  mret_commit_q <= is_mret_q;
                  state_q       <= S_INSERT;
               end
            end
            S_INSERT: begin
               intr_q  <= 1'b0;
               state_q <= S_IDLE;
            end
            S_SLEEP: begin
               // Wake on any enabled line regardless of mstatus_mie.
               if (|pend) begin
                  wfi_sleep_q <= 1'b0;
                  state_q     <= S_IDLE;
               end
            end
            default: state_q <= S_IDLE;
         endcase
      end
   end

   assign trap_bus.insert_pc   = insert_pc_q;
   assign trap_bus.priv_pc     = priv_pc_d;
   assign trap_bus.intr        = intr_q;
   assign trap_bus.trap_commit = trap_commit_q;
   assign trap_bus.mret_commit = mret_commit_q;
   assign trap_bus.mepc_o      = mepc_q;
   assign trap_bus.mcause_o    = cause_q;
   assign trap_bus.mtval_o     = tval_q;
   assign trap_bus.wfi_sleep   = wfi_sleep_q;
   assign dbg_state_o          = state_q;

endmodule

// File: tb/tb_prv_trap_ctrl.sv
// -----------------------------------------------------------------------------
// tb_prv_trap_ctrl
// Directed bench for prv_trap_ctrl. Each trap/mret pushes its expected redirect
// record into exp_q when driven; the record is popped and compared when
// insert_pc is observed. Inputs change and outputs are sampled 1 time unit
// after the rising edge.
// -----------------------------------------------------------------------------
module tb_prv_trap_ctrl;
   localparam int          XLEN      = 32;
   localparam logic [31:0] RESET_VEC = 32'h0000_0200;

   // ---------------- clock / reset ----------------
   logic       clk = 1'b0;
   logic       rst;
   logic [1:0] dbg_state;

   always #5 clk = ~clk;

   prv_trap_ctrl_if #(.XLEN(XLEN)) bus ();

   prv_trap_ctrl #(.XLEN(XLEN), .RESET_VEC(RESET_VEC)) dut (
      .CLK         (clk),
      .RST         (rst),
      .trap_bus    (bus),
      .dbg_state_o (dbg_state)
   );

   // ---------------- scoreboard ----------------
   typedef struct packed {
      logic [31:0] pc;
      logic [31:0] cause;
      logic [31:0] tval;
      logic [31:0] epc;
      logic        intr;
      logic        tc;
      logic        mc;
   } exp_t;

   exp_t exp_q[$];
   int   n_checks    = 0;
   int   n_fail      = 0;
   int   trap_pulses = 0;
   int   mret_pulses = 0;
   int   both_pulses = 0;
   int   exp_traps   = 0;
   int   exp_mrets   = 0;

   always @(negedge clk) begin
      if (bus.trap_commit === 1'b1) trap_pulses++;
      if (bus.mret_commit === 1'b1) mret_pulses++;
      if (bus.trap_commit === 1'b1 && bus.mret_commit === 1'b1) both_pulses++;
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
      n_checks++;
      assert (obs === expv)
      else begin
         n_fail++;
         $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, expv);
      end
   endtask

   // ---------------- driver tasks ----------------
   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic clear_events();
      bus.exc_vec     = '0;
      bus.mret        = 1'b0;
      bus.wfi         = 1'b0;
      bus.timer_int   = 1'b0;
      bus.soft_int    = 1'b0;
      bus.ext_int     = 1'b0;
      bus.mstatus_mie = 1'b0;
   endtask

   task automatic idle_inputs();
      clear_events();
      bus.pipe_clear = 1'b1;
      bus.epc        = '0;
      bus.badaddr    = '0;
      bus.curr_priv  = 2'd3;
      bus.mie_bits   = 3'b000;
      bus.mtvec      = 32'h0000_0100;
      bus.mepc_r     = '0;
   endtask

   task automatic push_exp(input logic [31:0] pc, input logic [31:0] cause,
                           input logic [31:0] tval, input logic [31:0] epc,
                           input logic intr, input logic tc, input logic mc);
      exp_t e;
      e.pc = pc; e.cause = cause; e.tval = tval; e.epc = epc;
      e.intr = intr; e.tc = tc; e.mc = mc;
      exp_q.push_back(e);
      if (tc) exp_traps++;
      if (mc) exp_mrets++;
   endtask

   // Waits (bounded) for insert_pc, checks remaining latency and the popped
   // record, then checks the strobes drop after exactly one cycle.
   task automatic wait_insert(input string tag, input int exp_lat);
      int   n;
      exp_t e;
      n = 0;
      while (bus.insert_pc !== 1'b1 && n < 20) begin
         cyc();
         n++;
      end
      check({tag, "_seen"}, 32'(bus.insert_pc), 32'd1);
      if (exp_q.size() == 0) begin
         check({tag, "_sb_empty"}, 32'd0, 32'd1);
      end else begin
         e = exp_q.pop_front();
         if (bus.insert_pc === 1'b1) begin
            check({tag, "_lat"},   n,                        exp_lat);
            check({tag, "_pc"},    bus.priv_pc,              e.pc);
            check({tag, "_cause"}, bus.mcause_o,             e.cause);
            check({tag, "_tval"},  bus.mtval_o,              e.tval);
            check({tag, "_mepc"},  bus.mepc_o,               e.epc);
            check({tag, "_intr"},  32'(bus.intr),            32'(e.intr));
            check({tag, "_tc"},    32'(bus.trap_commit),     32'(e.tc));
            check({tag, "_mc"},    32'(bus.mret_commit),     32'(e.mc));
            check({tag, "_state"}, 32'(dbg_state),           32'd2);
            cyc();
            check({tag, "_ins_drop"}, 32'(bus.insert_pc),    32'd0);
            check({tag, "_tc_drop"},  32'(bus.trap_commit),  32'd0);
            check({tag, "_mc_drop"},  32'(bus.mret_commit),  32'd0);
            check({tag, "_intr_drop"},32'(bus.intr),         32'd0);
            check({tag, "_idle"},     32'(dbg_state),        32'd0);
         end
      end
   endtask

   // ---------------- directed sequence ----------------
   initial begin
      int saved_tc;
      rst = 1'b1;
      idle_inputs();
      #12;
      check("rst_insert", 32'(bus.insert_pc),   32'd0);
      check("rst_pc",     bus.priv_pc,          RESET_VEC);
      check("rst_intr",   32'(bus.intr),        32'd0);
      check("rst_tc",     32'(bus.trap_commit), 32'd0);
      check("rst_mc",     32'(bus.mret_commit), 32'd0);
      check("rst_cause",  bus.mcause_o,         32'd0);
      check("rst_tval",   bus.mtval_o,          32'd0);
      check("rst_mepc",   bus.mepc_o,           32'd0);
      check("rst_sleep",  32'(bus.wfi_sleep),   32'd0);
      check("rst_state",  32'(dbg_state),       32'd0);
      @(negedge clk);
      rst = 1'b0;
      cyc();

      // Illegal instruction, direct vector, pipe already clear.
      bus.mtvec   = 32'h0000_0100;
      bus.exc_vec = 12'h004;
      bus.epc     = 32'h4000_0010;
      push_exp(32'h0000_0100, 32'd2, 32'd0, 32'h4000_0010, 1'b0, 1'b1, 1'b0);
      cyc();
      clear_events();
      check("ill_drain", 32'(dbg_state), 32'd1);
      wait_insert("ill", 1);

      // Soft + timer interrupt, vectored: soft wins, code 3 -> 0x10C.
      bus.mtvec       = 32'h0000_0101;
      bus.mstatus_mie = 1'b1;
      bus.mie_bits    = 3'b111;
      bus.timer_int   = 1'b1;
      bus.soft_int    = 1'b1;
      bus.epc         = 32'h1234_5676;
      push_exp(32'h0000_010C, 32'h8000_0003, 32'd0, 32'h1234_5674, 1'b1, 1'b1, 1'b0);
      cyc();
      clear_events();
      check("sint_intr_drain", 32'(bus.intr), 32'd1);
      wait_insert("sint", 1);

      // All three lines: external wins, code 11 -> 0x12C.
      bus.mstatus_mie = 1'b1;
      bus.timer_int   = 1'b1;
      bus.soft_int    = 1'b1;
      bus.ext_int     = 1'b1;
      bus.epc         = 32'h0000_0008;
      push_exp(32'h0000_012C, 32'h8000_000B, 32'd0, 32'h0000_0008, 1'b1, 1'b1, 1'b0);
      cyc();
      clear_events();
      wait_insert("eint", 1);

      // Breakpoint + fault_insn + enabled interrupt: breakpoint wins, tval=epc,
      // exceptions ignore vectored mode.
      bus.exc_vec     = 12'h009;
      bus.mstatus_mie = 1'b1;
      bus.timer_int   = 1'b1;
      bus.epc         = 32'h0000_0A02;
      bus.badaddr     = 32'h5555_5555;
      push_exp(32'h0000_0100, 32'd3, 32'h0000_0A02, 32'h0000_0A00, 1'b0, 1'b1, 1'b0);
      cyc();
      clear_events();
      wait_insert("bkpt", 1);

      // mal_l over store page fault, pipe held busy 5 cycles.
      bus.mtvec      = 32'h0000_0100;
      bus.exc_vec    = 12'h840;
      bus.badaddr    = 32'hDEAD_BEEE;
      bus.epc        = 32'h0000_0020;
      bus.pipe_clear = 1'b0;
      push_exp(32'h0000_0100, 32'd4, 32'hDEAD_BEEE, 32'h0000_0020, 1'b0, 1'b1, 1'b0);
      cyc();
      clear_events();
      for (int i = 0; i < 5; i++) begin
         cyc();
         check("mall_hold_ins",   32'(bus.insert_pc), 32'd0);
         check("mall_hold_state", 32'(dbg_state),     32'd1);
      end
      bus.pipe_clear = 1'b1;
      wait_insert("mall", 1);

      // mret together with env in M-mode: env wins, mret dropped.
      bus.exc_vec   = 12'h010;
      bus.mret      = 1'b1;
      bus.curr_priv = 2'd3;
      bus.mepc_r    = 32'h8000_0040;
      bus.epc       = 32'h0000_0044;
      push_exp(32'h0000_0100, 32'd11, 32'd0, 32'h0000_0044, 1'b0, 1'b1, 1'b0);
      cyc();
      clear_events();
      wait_insert("env_mret", 1);

      // Lone mret: returns to mepc_r, trap CSRs untouched.
      bus.mret = 1'b1;
      push_exp(32'h8000_0040, 32'd11, 32'd0, 32'h0000_0044, 1'b0, 1'b0, 1'b1);
      cyc();
      clear_events();
      wait_insert("mret", 1);

      // env from U-mode: cause 8.
      bus.exc_vec   = 12'h010;
      bus.curr_priv = 2'd0;
      bus.epc       = 32'h0000_0050;
      push_exp(32'h0000_0100, 32'd8, 32'd0, 32'h0000_0050, 1'b0, 1'b1, 1'b0);
      cyc();
      clear_events();
      wait_insert("env_u", 1);

      // Pending interrupt with mstatus_mie=0: nothing taken.
      bus.timer_int = 1'b1;
      bus.mie_bits  = 3'b111;
      for (int i = 0; i < 3; i++) begin
         cyc();
         check("mie_off_ins", 32'(bus.insert_pc), 32'd0);
      end

      // wfi while an enabled line is pending: NOP.
      bus.wfi = 1'b1;
      cyc();
      clear_events();
      check("wfi_nop_sleep", 32'(bus.wfi_sleep), 32'd0);
      check("wfi_nop_state", 32'(dbg_state),     32'd0);

      // wfi with nothing pending: sleep, then ext_int wakes without a trap.
      bus.mie_bits = 3'b000;
      bus.wfi      = 1'b1;
      cyc();
      bus.wfi = 1'b0;
      check("wfi_sleep", 32'(bus.wfi_sleep), 32'd1);
      check("wfi_state", 32'(dbg_state),     32'd3);
      cyc();
      check("wfi_stay", 32'(bus.wfi_sleep), 32'd1);
      bus.ext_int  = 1'b1;
      bus.mie_bits = 3'b100;
      cyc();
      check("wake_sleep", 32'(bus.wfi_sleep), 32'd0);
      check("wake_state", 32'(dbg_state),     32'd0);
      for (int i = 0; i < 3; i++) begin
         cyc();
         check("wake_no_trap", 32'(bus.insert_pc), 32'd0);
      end
      clear_events();
      bus.mie_bits = 3'b000;
      cyc();

      // Asynchronous reset while draining aborts with no commit.
      bus.exc_vec    = 12'h004;
      bus.pipe_clear = 1'b0;
      cyc();
      clear_events();
      check("rst_mid_drain", 32'(dbg_state), 32'd1);
      saved_tc = trap_pulses;
      #2;
      rst = 1'b1;
      #1;
      check("arst_insert", 32'(bus.insert_pc), 32'd0);
      check("arst_pc",     bus.priv_pc,        RESET_VEC);
      check("arst_state",  32'(dbg_state),     32'd0);
      check("arst_cause",  bus.mcause_o,       32'd0);
      @(negedge clk);
      rst = 1'b0;
      bus.pipe_clear = 1'b1;
      for (int i = 0; i < 4; i++) begin
         cyc();
         check("arst_no_insert", 32'(bus.insert_pc), 32'd0);
      end
      check("arst_no_commit", trap_pulses, saved_tc);

      // Final bookkeeping.
      check("sb_drained",   exp_q.size(), 32'd0);
      check("strobe_both",  both_pulses,  32'd0);
      check("trap_pulses",  trap_pulses,  exp_traps);
      check("mret_pulses",  mret_pulses,  exp_mrets);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
